// File: rtl/ps2_key_tracker.sv
// PS/2 frame receiver with make/break key tracking for the 7-segment display path.
// Optional build macro KEY_COUNT_BCD_EN selects a packed 2-digit BCD key_count.
module ps2_key_tracker #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic [7:0] key_count,
  output logic       disp_en,
  output logic       new_key,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, PRESSED, BREAK} key_state_t;

  function automatic logic [7:0] cnt_inc(input logic [7:0] c);
`ifdef KEY_COUNT_BCD_EN
    logic [3:0] tens, units;
    tens  = c[7:4];
    units = c[3:0];
    if (units == 4'd9) begin
      units = 4'd0;
      tens  = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      units = units + 4'd1;
    end
    return {tens, units};
`else
    return c + 8'd1;
`endif
  endfunction

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic                   clk_cur, data_cur, fall;

  // Stage p0: synchronise the asynchronous PS/2 lines and detect falling edges
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_cur;
    end
  end

  assign clk_cur  = clk_sync[SYNC_STAGES-1];
  assign data_cur = data_sync[SYNC_STAGES-1];
  assign fall     = clk_prev & ~clk_cur;

  logic [3:0]    bit_cnt;
  logic [TW-1:0] idle_cnt;
  logic [9:0]    sr;
  logic [10:0]   frame;
  logic          frame_done, frame_ok, byte_vld, timeout;
  logic [7:0]    rx_byte;

  assign frame      = {data_cur, sr};
  assign frame_done = fall && (bit_cnt == 4'd10);
  assign frame_ok   = ~frame[0] & frame[10] & (^frame[9:1]);
  assign byte_vld   = frame_done & frame_ok;
  assign rx_byte    = frame[8:1];
  assign timeout    = (bit_cnt != 4'd0) && !fall && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Stage p1: frame assembly; the 11th bit is taken straight from the synchroniser
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= 4'd0;
      idle_cnt <= '0;
    end else if (fall) begin
      idle_cnt <= '0;
      bit_cnt  <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
    end else if (timeout) begin
      bit_cnt  <= 4'd0;
      idle_cnt <= '0;
    end else if (bit_cnt != 4'd0) begin
      idle_cnt <= idle_cnt + TW'(1);
    end else begin
      idle_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (fall) sr <= {data_cur, sr[9:1]};
  end

  key_state_t state, state_n;
  logic [7:0] scan_n, cnt_n;
  logic       disp_n, nk_n, fe_n;

  always_comb begin
    state_n = state;
    scan_n  = scan_code;
    cnt_n   = key_count;
    disp_n  = disp_en;
    nk_n    = 1'b0;
    fe_n    = (frame_done & ~frame_ok) | timeout;
    if (byte_vld && rx_byte != 8'hE0) begin
      unique case (state)
        IDLE, PRESSED: begin
          if (rx_byte == 8'hF0) begin
            state_n = BREAK;
          end else if (state == IDLE || rx_byte != scan_code) begin
            state_n = PRESSED;
            scan_n  = rx_byte;
            disp_n  = 1'b1;
            cnt_n   = cnt_inc(key_count);
            nk_n    = 1'b1;
          end
        end
        BREAK: begin
          if (rx_byte == scan_code) begin
            disp_n  = 1'b0;
            state_n = IDLE;
          end else begin
            state_n = disp_en ? PRESSED : IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Stage p2: registered key state and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      scan_code <= 8'h00;
      key_count <= 8'h00;
      disp_en   <= 1'b0;
      new_key   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      scan_code <= scan_n;
      key_count <= cnt_n;
      disp_en   <= disp_n;
      new_key   <= nk_n;
      frame_err <= fe_n;
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: bit-banged PS/2 frames with hand-computed results.
module tb_ps2_key_tracker;

  localparam int TO = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code, key_count;
  logic       disp_en, new_key, frame_err;

  int n_chk = 0;
  int n_err = 0;
  int nk_cnt = 0;
  int fe_cnt = 0;
  int nk0, fe0;

  ps2_key_tracker #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .scan_code(scan_code), .key_count(key_count), .disp_en(disp_en),
    .new_key(new_key), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (new_key)   nk_cnt++;
    if (frame_err) fe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (2) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (6) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input logic perr, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ perr, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 1'b0, 11);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] code;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_scan", scan_code, 8'h00);
    chk("rst_cnt", key_count, 8'h00);
    chk("rst_disp", disp_en, 1'b0);
    chk("rst_nk", new_key, 1'b0);
    chk("rst_fe", frame_err, 1'b0);

    // 1: single press
    nk0 = nk_cnt;
    send_byte(8'h1C);
    chk("t1_scan", scan_code, 8'h1C);
    chk("t1_disp", disp_en, 1'b1);
    chk("t1_cnt", key_count, 8'h01);
    chk("t1_nk", nk_cnt - nk0, 1);

    // 2: typematic repeats, break, E0 ignored
    nk0 = nk_cnt;
    repeat (3) send_byte(8'h1C);
    chk("t2_rep_cnt", key_count, 8'h01);
    send_byte(8'hF0);
    chk("t2_f0_disp", disp_en, 1'b1);
    send_byte(8'h1C);
    chk("t2_cnt", key_count, 8'h01);
    chk("t2_disp", disp_en, 1'b0);
    chk("t2_scan", scan_code, 8'h1C);
    chk("t2_nk", nk_cnt - nk0, 0);
    send_byte(8'hE0);
    chk("t2_e0_cnt", key_count, 8'h01);
    chk("t2_e0_disp", disp_en, 1'b0);

    // 3: parity error
    fe0 = fe_cnt;
    send_bits(8'h1C, 1'b1, 11);
    chk("t3_fe", fe_cnt - fe0, 1);
    chk("t3_scan", scan_code, 8'h1C);
    chk("t3_cnt", key_count, 8'h01);
    chk("t3_disp", disp_en, 1'b0);

    // 4: timeout mid-frame, then clean frame
    fe0 = fe_cnt;
    send_bits(8'h32, 1'b0, 5);
    repeat (TO + 1) @(posedge clk);
    @(negedge clk);
    chk("t4_fe", fe_cnt - fe0, 1);
    send_byte(8'h32);
    chk("t4_scan", scan_code, 8'h32);
    chk("t4_cnt", key_count, 8'h02);
    chk("t4_disp", disp_en, 1'b1);
    chk("t4_fe_after", fe_cnt - fe0, 1);

    // 6: reset in the middle of a frame
    send_bits(8'h55, 1'b0, 6);
    ps2_data = 1'b1;
    do_reset();
    chk("t6_rst_scan", scan_code, 8'h00);
    chk("t6_rst_cnt", key_count, 8'h00);
    chk("t6_rst_disp", disp_en, 1'b0);
    send_byte(8'h1C);
    chk("t6_scan", scan_code, 8'h1C);
    chk("t6_cnt", key_count, 8'h01);
    chk("t6_disp", disp_en, 1'b1);

    // 5: 99 press/release pairs, then one more press
    do_reset();
    nk0 = nk_cnt;
    for (int i = 0; i < 99; i++) begin
      code = 8'h10 + 8'(i % 32);
      send_byte(code);
      send_byte(8'hF0);
      send_byte(code);
    end
`ifdef KEY_COUNT_BCD_EN
    chk("t5_cnt99", key_count, 8'h99);
`else
    chk("t5_cnt99", key_count, 8'd99);
`endif
    chk("t5_disp_rel", disp_en, 1'b0);
    send_byte(8'h40);
`ifdef KEY_COUNT_BCD_EN
    chk("t5_cnt_wrap", key_count, 8'h00);
`else
    chk("t5_cnt100", key_count, 8'd100);
`endif
    chk("t5_scan", scan_code, 8'h40);
    chk("t5_disp", disp_en, 1'b1);
    chk("t5_nk", nk_cnt - nk0, 100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
